decoder_416_seq: RTL

- Sequential 4-to-16 decoder: the decode-side counterpart of the 16-line-to-4 priority encoder.
- Accepts encoded request codes (4-bit index plus GS-style valid flag) over a valid/ready handshake and queues them in a small FIFO.
- Replays each code as a one-hot 16-line strobe held for HOLD cycles, with encoder-style EI/GS/EO cascade signals.
- Sits downstream of encoder_164-type logic to regenerate line-level strobes.

---
 rtl/decoder_pkg.sv | 8 +
 rtl/decoder_416.sv | 21 ++
 rtl/decoder_416_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and widths for the sequential 4-to-16 decoder slice.
// No logic, so no latency.
// No flow control at this level.
package decoder_pkg;
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam int ENTRY_W = 5;
    localparam int LINES   = 16;
endpackage

// File: rtl/decoder_416.sv
// Combinational 4-to-16 line decoder with enable and code-valid inputs.
// Zero latency; purely combinational.
// No backpressure; output follows inputs.
module decoder_416
    import decoder_pkg::*;
(
    input  logic             ei,
    input  logic             gs_in,
    input  logic [3:0]       code,
    output logic [LINES-1:0] y,
    output logic             gs_out
);
    always_comb begin
        y = '0;
        if (ei && gs_in) begin
            y = LINES'(1) << code;
        end
    end

    assign gs_out = |y;
endmodule

// File: rtl/decoder_416_seq.sv
// Queues encoded codes and replays each as a one-hot strobe held for HOLD cycles.
// Code accepted into an empty, idle queue appears on y one edge after acceptance.
// in_ready drops when the queue is full or in reset; no push-through when full.
module decoder_416_seq
    import decoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ei,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_code,
    input  logic                      in_gs,
    output logic [LINES-1:0]          y,
    output logic                      gs,
    output logic                      eo,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count_q;
    logic               full, empty, push, pop;

    state_t             state, state_n;
    logic [7:0]         hold_cnt, hold_n;
    logic [LINES-1:0]   y_q, y_n, dec_y;
    logic               gs_q, gs_n, dec_gs;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    decoder_416 u_dec (
        .ei     (ei),
        .gs_in  (head[ENTRY_W-1]),
        .code   (head[3:0]),
        .y      (dec_y),
        .gs_out (dec_gs)
    );

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        y_n     = y_q;
        gs_n    = gs_q;
        pop     = 1'b0;
        if (!ei) begin
            // Abandon the current slot; queued entries stay put.
            state_n = IDLE;
            hold_n  = '0;
            y_n     = '0;
            gs_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    y_n  = '0;
                    gs_n = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        y_n     = dec_y;
                        gs_n    = dec_gs;
                        hold_n  = HOLD_M1;
                        state_n = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (hold_cnt != '0) begin
                        hold_n = hold_cnt - 8'd1;
                    end else if (!empty) begin
                        pop    = 1'b1;
                        y_n    = dec_y;
                        gs_n   = dec_gs;
                        hold_n = HOLD_M1;
                    end else begin
                        state_n = IDLE;
                        y_n     = '0;
                        gs_n    = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            state    <= IDLE;
            hold_cnt <= '0;
            y_q      <= '0;
            gs_q     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q  <= count_q + CW'(push) - CW'(pop);
            state    <= state_n;
            hold_cnt <= hold_n;
            y_q      <= y_n;
            gs_q     <= gs_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_gs, in_code};
    end

    assign y     = y_q;
    assign gs    = gs_q;
    assign count = count_q;
    assign eo    = ei && (state == IDLE) && empty;
endmodule
